// File: rtl/mux_scan_seq.sv
// Scan sequencer for a 16:1 mux: steps sel, waits SETTLE_CYC cycles, samples mux_out.
// Optional back-to-back scanning is enabled by defining MUX_SCAN_CONT_EN (adds port cont).
module mux_scan_seq #(
  parameter int SEL_W      = 4,
  parameter int N_IN       = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
`ifdef MUX_SCAN_CONT_EN
  input  logic             cont,
`endif
  input  logic             mux_out,
  output logic [SEL_W-1:0] sel,
  output logic             bit_valid,
  output logic             bit_data,
  output logic [SEL_W-1:0] bit_idx,
  output logic [N_IN-1:0]  word,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  localparam int                CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_IN - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic [SEL_W-1:0] bit_idx_reg, bit_idx_next;
  logic [N_IN-1:0]  word_reg, word_next;
  logic             bit_valid_reg, bit_valid_next;
  logic             bit_data_reg, bit_data_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             word_clr, cap_en;
  logic             cont_i;
  logic             last_bit;

`ifdef MUX_SCAN_CONT_EN
  assign cont_i = cont;
`else
  assign cont_i = 1'b0;
`endif

  assign last_bit = (sel_reg == SEL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      sel_reg       <= '0;
      bit_idx_reg   <= '0;
      word_reg      <= '0;
      bit_valid_reg <= 1'b0;
      bit_data_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      sel_reg       <= sel_next;
      bit_idx_reg   <= bit_idx_next;
      word_reg      <= word_next;
      bit_valid_reg <= bit_valid_next;
      bit_data_reg  <= bit_data_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && !abort) state_next = SETTLE;
      SETTLE:  if (abort) state_next = IDLE;
               else if (cnt_reg == CNT_LAST) state_next = SAMPLE;
      SAMPLE:  if (abort || (last_bit && !cont_i)) state_next = IDLE;
               else state_next = SETTLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next       = cnt_reg;
    sel_next       = sel_reg;
    bit_idx_next   = bit_idx_reg;
    bit_data_next  = bit_data_reg;
    bit_valid_next = 1'b0;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    word_clr       = 1'b0;
    cap_en         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          sel_next  = '0;
          cnt_next  = '0;
          busy_next = 1'b1;
          word_clr  = 1'b1;
        end
      end
      SETTLE: begin
        if (abort) begin
          sel_next  = '0;
          cnt_next  = '0;
          busy_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      SAMPLE: begin
        // abort wins over the capture: the partial word is left untouched
        if (abort) begin
          sel_next  = '0;
          cnt_next  = '0;
          busy_next = 1'b0;
        end else begin
          cap_en         = 1'b1;
          bit_valid_next = 1'b1;
          bit_data_next  = mux_out;
          bit_idx_next   = sel_reg;
          cnt_next       = '0;
          if (!last_bit) begin
            sel_next = sel_reg + 1'b1;
          end else begin
            sel_next  = '0;
            done_next = 1'b1;
            if (cont_i) word_clr  = 1'b1;
            else        busy_next = 1'b0;
          end
        end
      end
      default: begin
        sel_next  = '0;
        cnt_next  = '0;
        busy_next = 1'b0;
      end
    endcase
  end

  // Per-bit word update; a restart clear takes precedence over the final capture
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_word
    assign word_next[gi] = word_clr ? 1'b0 :
                           (cap_en && (sel_reg == SEL_W'(gi))) ? mux_out : word_reg[gi];
  end

  assign sel       = sel_reg;
  assign bit_valid = bit_valid_reg;
  assign bit_data  = bit_data_reg;
  assign bit_idx   = bit_idx_reg;
  assign word      = word_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq: instance a (SETTLE_CYC=2, ideal mux),
// instance b (SETTLE_CYC=1, mux output lagging sel by one cycle).
module tb_mux_scan_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_a = 1'b0, abort_a = 1'b0;
  logic        start_b = 1'b0, abort_b = 1'b0;
  logic [15:0] pat_a = 16'h1234;
  logic [15:0] pat_b = 16'hFFFF;
  logic        mux_out_a, mux_d;
  logic [3:0]  sel_a, bit_idx_a, sel_b, bit_idx_b;
  logic        bit_valid_a, bit_data_a, busy_a, done_a;
  logic        bit_valid_b, bit_data_b, busy_b, done_b;
  logic [15:0] word_a, word_b;
`ifdef MUX_SCAN_CONT_EN
  logic        cont_a = 1'b0;
  logic        cont_b = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mux_out_a = pat_a[sel_a];
  always @(posedge clk) mux_d <= pat_b[sel_b];

  mux_scan_seq #(.SEL_W(4), .N_IN(16), .SETTLE_CYC(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
`ifdef MUX_SCAN_CONT_EN
    .cont(cont_a),
`endif
    .mux_out(mux_out_a), .sel(sel_a), .bit_valid(bit_valid_a), .bit_data(bit_data_a),
    .bit_idx(bit_idx_a), .word(word_a), .busy(busy_a), .done(done_a)
  );

  mux_scan_seq #(.SEL_W(4), .N_IN(16), .SETTLE_CYC(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
`ifdef MUX_SCAN_CONT_EN
    .cont(cont_b),
`endif
    .mux_out(mux_d), .sel(sel_b), .bit_valid(bit_valid_b), .bit_data(bit_data_b),
    .bit_idx(bit_idx_b), .word(word_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, " sel"}, sel_a, 0);
    chk({tag, " busy"}, busy_a, 0);
    chk({tag, " done"}, done_a, 0);
    chk({tag, " bit_valid"}, bit_valid_a, 0);
  endtask

  // Full scan on instance a; optional start pulses at edges sp1/sp2 (0 = none)
  task automatic scan_a(input logic [15:0] pat, input int sp1, input int sp2);
    pat_a = pat;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    $display("scan_a start pat=%h busy=%0b word=%h", pat, busy_a, word_a);
    chk("start busy", busy_a, 1);
    chk("start sel", sel_a, 0);
    chk("start word", word_a, 0);
    for (int k = 1; k <= 48; k++) begin
      start_a = (k == sp1) || (k == sp2);
      step();
      start_a = 1'b0;
      chk("bit_valid", bit_valid_a, (k % 3 == 0) ? 1 : 0);
      chk("sel", sel_a, (k == 48) ? 0 : k / 3);
      chk("busy", busy_a, (k < 48) ? 1 : 0);
      chk("done", done_a, (k == 48) ? 1 : 0);
      if (k % 3 == 0) begin
        chk("bit_idx", bit_idx_a, k / 3 - 1);
        chk("bit_data", bit_data_a, pat[k/3-1]);
        $display("edge %0d bit_idx=%0d bit_data=%0b", k, bit_idx_a, bit_data_a);
      end
    end
    chk("final word", word_a, pat);
    $display("scan_a end word=%h done=%0b busy=%0b", word_a, done_a, busy_a);
  endtask

  task automatic scan_b(input logic [15:0] pat);
    pat_b = pat;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("b start word", word_b, 0);
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("b bit_valid", bit_valid_b, (k % 2 == 0) ? 1 : 0);
      chk("b done", done_b, (k == 32) ? 1 : 0);
      if (k % 2 == 0) begin
        chk("b bit_idx", bit_idx_b, k / 2 - 1);
        chk("b bit_data", bit_data_b, pat[k/2-1]);
      end
    end
    chk("b word", word_b, pat);
    chk("b busy", busy_b, 0);
    $display("scan_b pat=%h word=%h", pat, word_b);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk_idle_a("reset");
    chk("reset word", word_a, 0);
    chk("reset bit_idx", bit_idx_a, 0);
    chk("reset bit_data", bit_data_a, 0);
    step();
    step();
    #2 rst_n = 1'b1;
    step();
    chk_idle_a("post reset");
    $display("reset released busy=%0b", busy_a);

    scan_a(16'h1234, 0, 0);
    scan_a(16'h1234, 10, 20);

    // Start immediately after done, then abort on the capture edge of bit 4
    pat_a = 16'hA5A5;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("restart busy", busy_a, 1);
    chk("restart word", word_a, 0);
    for (int k = 1; k <= 15; k++) begin
      abort_a = (k == 15);
      step();
      abort_a = 1'b0;
      if (k < 15) chk("pre-abort bit_valid", bit_valid_a, (k % 3 == 0) ? 1 : 0);
    end
    chk_idle_a("abort");
    chk("abort word", word_a, 16'h0005);
    $display("abort word=%h busy=%0b sel=%0d", word_a, busy_a, sel_a);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_idle_a("after abort");
      chk("after abort word", word_a, 16'h0005);
    end

    // abort has priority over start in IDLE
    start_a = 1'b1;
    abort_a = 1'b1;
    step();
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("start+abort busy", busy_a, 0);
    $display("start+abort busy=%0b", busy_a);

    // Asynchronous reset while sel=7 is settling
    pat_a = 16'h1234;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 1; k <= 21; k++) step();
    chk("pre-reset sel", sel_a, 7);
    chk("pre-reset word", word_a, 16'h0034);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_a("async reset");
    chk("async reset word", word_a, 0);
    chk("async reset bit_idx", bit_idx_a, 0);
    chk("async reset bit_data", bit_data_a, 0);
    $display("async reset word=%h sel=%0d busy=%0b", word_a, sel_a, busy_a);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_idle_a("idle after reset");
    end

    // Lagging mux, single-cycle settle
    scan_b(16'hFFFF);
    scan_b(16'h1234);

`ifdef MUX_SCAN_CONT_EN
    pat_a = 16'h1234;
    cont_a = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 1; k <= 96; k++) begin
      step();
      if (k == 48) cont_a = 1'b0;
      chk("cont busy", busy_a, (k < 96) ? 1 : 0);
      chk("cont done", done_a, (k == 48 || k == 96) ? 1 : 0);
      if (k == 48) begin
        chk("cont sel wrap", sel_a, 0);
        chk("cont word clear", word_a, 0);
      end
    end
    chk("cont word", word_a, 16'h1234);
    $display("cont scan word=%h busy=%0b", word_a, busy_a);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
Sequencer that sits directly upstream and downstream of mux16to1. It drives the mux `sel` input through indices 0..N_IN-1. After each select change it waits a programmable settle time, then samples the mux `out`. It emits each sampled bit as a one-cycle strobe and assembles all sampled bits into a parallel word.

Parameters:
SEL_W, 4, select width; drives mux sel.
N_IN, 16, number of mux inputs scanned; must equal 2**SEL_W.
SETTLE_CYC, 2, cycles sel is held before sampling; legal range 1..15; 0 is illegal.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a scan; accepted only when busy=0.
abort  input  1  cancel an in-progress scan; ignored when idle.
mux_out  input  1  mux output being sampled.
sel  output  SEL_W  registered select driven to the mux.
bit_valid  output  1  one-cycle strobe: a bit was just sampled.
bit_data  output  1  sampled bit; valid when bit_valid=1.
bit_idx  output  SEL_W  index of the sampled bit; valid when bit_valid=1.
word  output  N_IN  assembled word; word[i] = bit sampled at sel=i.
busy  output  1  scan in progress.
done  output  1  one-cycle pulse when a full scan completes.

Behaviour:
- Reset (rst_n=0, async): sel=0, word=0, bit_valid=0, bit_data=0, bit_idx=0, busy=0, done=0. FSM goes to IDLE, settle counter=0.
- FSM states: IDLE, SETTLE, SAMPLE.
- IDLE:
  - start=1 and abort=0 at an edge -> SETTLE, sel=0, word=0, busy=1, cnt=0.
  - abort=1 in IDLE has priority; start is ignored.
- SETTLE: cnt increments each edge. At the edge where cnt==SETTLE_CYC-1 -> SAMPLE. SETTLE therefore lasts exactly SETTLE_CYC cycles.
- SAMPLE (one cycle), at the exiting edge:
  - word[sel]<=mux_out, bit_data<=mux_out, bit_idx<=sel, bit_valid<=1 for one cycle.
  - If sel<N_IN-1: sel<=sel+1, cnt<=0, -> SETTLE.
  - If sel==N_IN-1: sel<=0, busy<=0, done<=1 for one cycle, -> IDLE. There is no wrap-through of sel while busy.
- Per-bit period is SETTLE_CYC+1 cycles. With start accepted at edge E, the last capture and done occur at edge E+N_IN*(SETTLE_CYC+1). For the defaults that is E+48.
- bit_valid and done are deasserted on every edge where they are not explicitly set.
- start while busy=1 is ignored (no queuing). start is re-accepted at any edge after busy has fallen.
- abort=1 while busy, at that edge:
  - -> IDLE, busy=0, sel=0, cnt=0.
  - No done pulse.
  - abort beats a coincident SAMPLE capture: no bit_valid and no word update that edge.
  - word keeps the partial result.
- mux_out is sampled only in SAMPLE; its value in other states is don't-care.

Optional Feature:
Macro MUX_SCAN_CONT_EN.
- Defined: adds input port `cont` (1 bit). If cont=1 at the final SAMPLE edge:
  - done pulses as normal.
  - FSM goes directly to SETTLE with sel=0, word=0, cnt=0.
  - busy stays 1 with no idle gap.
  - abort still terminates as above.
- Undefined: port `cont` is absent and every scan is one-shot.

Test Plan:
- Reset mid-scan: assert rst_n=0 asynchronously at bit 7 -> all outputs read 0 immediately, before the next clk edge. After release, busy stays 0 until start.
- Nominal scan: mux model with in=16'h1234, SETTLE_CYC=2, start pulse at edge 0 ->
  - bit_valid strobes every 3 cycles at edges 3,6,...,48.
  - bit_data sequence for bit_idx 0..15 is 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0.
  - word=16'h1234, done=1 at edge 48 only, busy=0 from edge 48.
- Settle check: mux model whose out changes 1 cycle after sel, in=16'hFFFF, SETTLE_CYC=1 -> word=16'hFFFF. Sel stays stable for 2 cycles before each capture.
- Start while busy: pulse start at edges 10 and 20 during a scan -> no restart, done still at edge 48. Start at edge 49 -> new scan begins and word clears to 0.
- Abort: in=16'hA5A5, abort at edge 15 (coincident with capture of bit 4) ->
  - busy=0 and sel=0 after edge 15.
  - No bit_valid at edge 15, no done.
  - word=16'h0005 (bits 0..3 only).
- MUX_SCAN_CONT_EN with cont=1 -> two back-to-back scans. done pulses at edges 48 and 96, busy is continuously 1, sel returns to 0 at edge 48.
